vector_element_extract_unit: RTL and testbench
==============================================

VECTOR_ELEMENT_EXTRACT_UNIT -- requirements
Module: vector_element_extract_unit

Interface
REQ-001 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have req_valid_i  input  1  extraction request valid.
REQ-004 SHALL have req_ready_o  output  1  unit idle, can accept a request.
REQ-005 SHALL have vs2_addr_i  input  5  base vector register of source group.
REQ-006 SHALL have elem_idx_i  input  7  element index within group, 0..127.
REQ-007 SHALL have vsew_i  input  2  SEW: 00=8, 01=16, 10=32, 11=64 bits.
REQ-008 SHALL have vlmul_i  input  2  LMUL: 00=1, 01=2, 10=4, 11=8 registers.
REQ-009 SHALL have vrf_rd_en_o  output  1  vector register file read strobe.
REQ-010 SHALL have vrf_rd_addr_o  output  5  vector register file read address.
REQ-011 SHALL have vrf_rd_data_i  input  128  read data, valid exactly one cycle after vrf_rd_en_o.
REQ-012 SHALL have flush_i  input  1  synchronous abort of the in-flight extraction.
REQ-013 SHALL have rd_valid_o  output  1  scalar result valid.
REQ-014 SHALL have rd_ready_i  input  1  consumer accepts result.
REQ-015 SHALL have rd_data_o  output  64  extracted element, sign-extended to 64 bits.
REQ-016 SHALL have rd_oob_o  output  1  qualifies rd_data_o: index was out of range.

Function
REQ-017 SHALL implement FSM states IDLE, READ, CAPTURE, RESP.
REQ-018 IDLE: req_ready_o=1; on req_valid_i, SHALL register vs2_addr_i, elem_idx_i, vsew_i, vlmul_i and go to READ, or to RESP if out of range.
REQ-019 Elements per register SHALL be EPR=16>>vsew; VLMAX=EPR<<vlmul; out of range when elem_idx >= VLMAX.
REQ-020 READ: vrf_rd_en_o=1 for exactly one cycle; vrf_rd_addr_o=(vs2_addr + (elem_idx>>(4-vsew))) mod 32 (5-bit wrap); next CAPTURE.
REQ-021 CAPTURE: SHALL select lane (elem_idx & (EPR-1)) at bit offset lane*SEW from vrf_rd_data_i, sign-extend to 64, register into rd_data_o; rd_oob_o=0; next RESP.
REQ-022 Out-of-range path SHALL issue no VRF read and SHALL load rd_data_o=0, rd_oob_o=1.
REQ-023 RESP: rd_valid_o=1, rd_data_o/rd_oob_o stable until rd_valid_o&rd_ready_i; then IDLE.
REQ-024 In-range latency SHALL be accept cycle +3 to rd_valid_o; out-of-range +1.
REQ-025 req_ready_o SHALL be 0 in all states but IDLE; no new request accepted in the cycle the result is consumed.
REQ-026 flush_i SHALL force IDLE next cycle from any state, drop the result, and ignore vrf_rd_data_i; flush_i in IDLE SHALL block acceptance that cycle.
REQ-027 vrf_rd_en_o SHALL be 0 outside READ; vrf_rd_addr_o SHALL be 0 when vrf_rd_en_o=0.

Reset
REQ-028 On rstn_i low SHALL immediately set state=IDLE, rd_valid_o=0, rd_data_o=0, rd_oob_o=0, vrf_rd_en_o=0, vrf_rd_addr_o=0, registered request fields=0.
REQ-029 Reset mid-operation SHALL discard the extraction; after release, req_ready_o=1 in the first cycle.

Structure
REQ-030 SEW/LMUL encodings, state encoding and EPR/VLMAX constants SHALL live in shared package vector_pkg.
REQ-031 Lane selection and sign extension SHALL be a combinational sub-module vector_element_select (128-bit data, SEW, lane in; 64-bit out).

Verification
REQ-032 SEW=8, LMUL=1, vs2=3, idx=5, reg3 byte5=0x80 -> read addr 3, rd_data_o=0xFFFF_FFFF_FFFF_FF80 at accept+3, rd_oob_o=0.
REQ-033 SEW=32, LMUL=4, vs2=8, idx=9 -> read addr 10, lane 1 (bits 63:32)=0x1234_5678 -> rd_data_o=0x0000_0000_1234_5678.
REQ-034 SEW=64, LMUL=8, vs2=30, idx=5 -> read addr 0 (wrap), rd_data_o=reg0 bits127:64.
REQ-035 SEW=16, LMUL=1, idx=8 -> no vrf_rd_en_o, rd_valid_o at accept+1, rd_data_o=0, rd_oob_o=1.
REQ-036 rd_ready_i held 0 for 5 cycles -> rd_valid_o and rd_data_o stable, req_ready_o=0 throughout; flush_i in CAPTURE -> no rd_valid_o, IDLE next cycle.
REQ-037 rstn_i low during READ -> all outputs 0 asynchronously; after release, new request completes normally.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared encodings and geometry helpers for scalar extraction from a
// 128-bit-per-register vector register file.
package vector_pkg;

    localparam int VLEN = 128;
    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        LMUL_1 = 2'b00,
        LMUL_2 = 2'b01,
        LMUL_4 = 2'b10,
        LMUL_8 = 2'b11
    } lmul_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_READ    = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    // Elements per register: 16, 8, 4, 2.
    function automatic logic [4:0] epr(input sew_e sew);
        return 5'd16 >> sew;
    endfunction

    // Largest group length is 16 << 3 = 128, so 8 bits are needed.
    function automatic logic [7:0] vlmax(input sew_e sew, input lmul_e lmul);
        return {3'b000, epr(sew)} << lmul;
    endfunction

    // log2(EPR): shift that turns an element index into a register offset.
    function automatic logic [2:0] reg_shift(input sew_e sew);
        return 3'd4 - {1'b0, sew};
    endfunction

endpackage

// File: rtl/vector_element_select.sv
// Combinational lane picker: selects one SEW-wide element from a 128-bit
// register image and sign-extends it to 64 bits.
module vector_element_select
    import vector_pkg::*;
(
    input  logic [VLEN-1:0] data_i,
    input  sew_e            sew_i,
    input  logic [3:0]      lane_i,
    output logic [XLEN-1:0] elem_o
);

    logic [7:0]  elem_b;
    logic [15:0] elem_h;
    logic [31:0] elem_w;
    logic [63:0] elem_d;

    always_comb begin
        // Upper lane bits beyond EPR-1 are ignored for the wider element sizes.
        elem_b = data_i[{lane_i, 3'b000} +: 8];
        elem_h = data_i[{lane_i[2:0], 4'b0000} +: 16];
        elem_w = data_i[{lane_i[1:0], 5'b00000} +: 32];
        elem_d = data_i[{lane_i[0], 6'b000000} +: 64];
        elem_o = '0;
        case (sew_i)
            SEW_8:   elem_o = {{56{elem_b[7]}}, elem_b};
            SEW_16:  elem_o = {{48{elem_h[15]}}, elem_h};
            SEW_32:  elem_o = {{32{elem_w[31]}}, elem_w};
            SEW_64:  elem_o = elem_d;
            default: elem_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_element_extract_unit.sv
// Reads one element of a vector register group through a single VRF read
// port and returns it as a sign-extended 64-bit scalar.
//
// state   | meaning
// IDLE    | ready for a request; range check decided at accept
// READ    | VRF read strobe and address driven for one cycle
// CAPTURE | VRF data valid; lane selected and registered
// RESP    | result held until the consumer takes it
module vector_element_extract_unit
    import vector_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [4:0]       vs2_addr_i,
    input  logic [6:0]       elem_idx_i,
    input  logic [1:0]       vsew_i,
    input  logic [1:0]       vlmul_i,
    output logic             vrf_rd_en_o,
    output logic [4:0]       vrf_rd_addr_o,
    input  logic [VLEN-1:0]  vrf_rd_data_i,
    input  logic             flush_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             rd_oob_o
);

    state_e      state;
    logic [4:0]  vs2_q;
    logic [6:0]  idx_q;
    sew_e        sew_q;
    lmul_e       lmul_q;

    sew_e        sew_in;
    lmul_e       lmul_in;
    logic        req_oob;
    logic [4:0]  req_addr;
    logic [3:0]  lane;
    logic        q_in_range;
    logic [XLEN-1:0] elem_ext;

    assign sew_in   = sew_e'(vsew_i);
    assign lmul_in  = lmul_e'(vlmul_i);
    assign req_oob  = {1'b0, elem_idx_i} >= vlmax(sew_in, lmul_in);
    // Register offset wraps modulo 32 with the 5-bit add.
    assign req_addr = vs2_addr_i + 5'(elem_idx_i >> reg_shift(sew_in));

    assign lane       = idx_q[3:0] & 4'(epr(sew_q) - 5'd1);
    assign q_in_range = {1'b0, idx_q} < vlmax(sew_q, lmul_q);

    vector_element_select u_select (
        .data_i (vrf_rd_data_i),
        .sew_i  (sew_q),
        .lane_i (lane),
        .elem_o (elem_ext)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= ST_IDLE;
            req_ready_o   <= 1'b1;
            vrf_rd_en_o   <= 1'b0;
            vrf_rd_addr_o <= '0;
            rd_valid_o    <= 1'b0;
            rd_data_o     <= '0;
            rd_oob_o      <= 1'b0;
            vs2_q         <= '0;
            idx_q         <= '0;
            sew_q         <= SEW_8;
            lmul_q        <= LMUL_1;
        end else if (flush_i) begin
            state         <= ST_IDLE;
            req_ready_o   <= 1'b1;
            vrf_rd_en_o   <= 1'b0;
            vrf_rd_addr_o <= '0;
            rd_valid_o    <= 1'b0;
            rd_data_o     <= '0;
            rd_oob_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        vs2_q       <= vs2_addr_i;
                        idx_q       <= elem_idx_i;
                        sew_q       <= sew_in;
                        lmul_q      <= lmul_in;
                        req_ready_o <= 1'b0;
                        if (req_oob) begin
                            state      <= ST_RESP;
                            rd_valid_o <= 1'b1;
                            rd_data_o  <= '0;
                            rd_oob_o   <= 1'b1;
                        end else begin
                            state         <= ST_READ;
                            vrf_rd_en_o   <= 1'b1;
                            vrf_rd_addr_o <= req_addr;
                        end
                    end
                end
                ST_READ: begin
                    vrf_rd_en_o   <= 1'b0;
                    vrf_rd_addr_o <= '0;
                    state         <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Only in-range requests reach here; the guard keeps a
                    // corrupted request from ever leaking stale lane data.
                    rd_data_o  <= q_in_range ? elem_ext : '0;
                    rd_oob_o   <= 1'b0;
                    rd_valid_o <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rd_ready_i) begin
                        rd_valid_o  <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_element_extract_unit.sv
// Directed bench for vector_element_extract_unit with a one-cycle-latency
// VRF model and hand-computed expected results.
module tb_vector_element_extract_unit;

    logic         clk_i;
    logic         rstn_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [4:0]   vs2_addr_i;
    logic [6:0]   elem_idx_i;
    logic [1:0]   vsew_i;
    logic [1:0]   vlmul_i;
    logic         vrf_rd_en_o;
    logic [4:0]   vrf_rd_addr_o;
    logic [127:0] vrf_rd_data_i;
    logic         flush_i;
    logic         rd_valid_o;
    logic         rd_ready_i;
    logic [63:0]  rd_data_o;
    logic         rd_oob_o;

    logic [127:0] vrf_mem [32];
    int checks = 0;
    int errors = 0;

    vector_element_extract_unit dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .vs2_addr_i    (vs2_addr_i),
        .elem_idx_i    (elem_idx_i),
        .vsew_i        (vsew_i),
        .vlmul_i       (vlmul_i),
        .vrf_rd_en_o   (vrf_rd_en_o),
        .vrf_rd_addr_o (vrf_rd_addr_o),
        .vrf_rd_data_i (vrf_rd_data_i),
        .flush_i       (flush_i),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_data_o     (rd_data_o),
        .rd_oob_o      (rd_oob_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // VRF returns data one cycle after the strobe; garbage otherwise.
    always @(posedge clk_i) begin
        if (vrf_rd_en_o)
            vrf_rd_data_i <= vrf_mem[vrf_rd_addr_o];
        else
            vrf_rd_data_i <= {4{32'hA5A5_5A5A}};
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [4:0] vs2, input logic [6:0] idx,
                       input logic [1:0] sew, input logic [1:0] lmul);
        vs2_addr_i  = vs2;
        elem_idx_i  = idx;
        vsew_i      = sew;
        vlmul_i     = lmul;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic run_in(input string tag, input logic [4:0] vs2, input logic [6:0] idx,
                          input logic [1:0] sew, input logic [1:0] lmul,
                          input logic [4:0] exp_addr, input logic [63:0] exp_data);
        req(vs2, idx, sew, lmul);
        chk($sformatf("%s_rd_en", tag), 64'(vrf_rd_en_o), 64'd1);
        chk($sformatf("%s_addr", tag), 64'(vrf_rd_addr_o), 64'(exp_addr));
        tick();
        chk($sformatf("%s_capture_valid", tag), 64'(rd_valid_o), 64'd0);
        tick();
        chk($sformatf("%s_valid", tag), 64'(rd_valid_o), 64'd1);
        chk($sformatf("%s_data", tag), rd_data_o, exp_data);
        chk($sformatf("%s_oob", tag), 64'(rd_oob_o), 64'd0);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        chk($sformatf("%s_consumed", tag), 64'(rd_valid_o), 64'd0);
    endtask

    initial begin
        rstn_i      = 1'b0;
        req_valid_i = 1'b0;
        vs2_addr_i  = '0;
        elem_idx_i  = '0;
        vsew_i      = '0;
        vlmul_i     = '0;
        flush_i     = 1'b0;
        rd_ready_i  = 1'b0;
        for (int i = 0; i < 32; i++) vrf_mem[i] = {4{32'(i)}};
        vrf_mem[0]  = 128'hFEDCBA98_76543210_00112233_44556677;
        vrf_mem[3]  = 128'h11223344_55667788_99AA80CC_DDEEFF00;
        vrf_mem[10] = 128'hCAFEF00D_87654321_12345678_9ABCDEF0;

        #3;
        chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_rd_en", 64'(vrf_rd_en_o), 64'd0);
        chk("rst_rd_addr", 64'(vrf_rd_addr_o), 64'd0);
        chk("rst_rd_data", rd_data_o, 64'd0);
        chk("rst_rd_oob", 64'(rd_oob_o), 64'd0);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
        chk("idle_ready", 64'(req_ready_o), 64'd1);

        // SEW8 LMUL1 vs2=3 idx=5: byte 5 of v3 is 0x80.
        req(5'd3, 7'd5, 2'b00, 2'b00);
        chk("t1_rd_en", 64'(vrf_rd_en_o), 64'd1);
        chk("t1_addr", 64'(vrf_rd_addr_o), 64'd3);
        chk("t1_ready_busy", 64'(req_ready_o), 64'd0);
        chk("t1_valid_early", 64'(rd_valid_o), 64'd0);
        tick();
        chk("t1_rd_en_once", 64'(vrf_rd_en_o), 64'd0);
        chk("t1_addr_zero", 64'(vrf_rd_addr_o), 64'd0);
        chk("t1_valid_cap", 64'(rd_valid_o), 64'd0);
        tick();
        chk("t1_valid", 64'(rd_valid_o), 64'd1);
        chk("t1_data", rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("t1_oob", 64'(rd_oob_o), 64'd0);

        // Consume while a new request is already waiting: it must not be taken.
        vs2_addr_i  = 5'd8;
        elem_idx_i  = 7'd9;
        vsew_i      = 2'b10;
        vlmul_i     = 2'b10;
        req_valid_i = 1'b1;
        rd_ready_i  = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        chk("t1_consumed", 64'(rd_valid_o), 64'd0);
        chk("t2_not_taken", 64'(vrf_rd_en_o), 64'd0);
        chk("t2_ready_idle", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = 1'b0;
        chk("t2_rd_en", 64'(vrf_rd_en_o), 64'd1);
        chk("t2_addr", 64'(vrf_rd_addr_o), 64'd10);
        tick();
        tick();
        chk("t2_valid", 64'(rd_valid_o), 64'd1);
        chk("t2_data", rd_data_o, 64'h0000_0000_1234_5678);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t2_stall%0d_valid", i), 64'(rd_valid_o), 64'd1);
            chk($sformatf("t2_stall%0d_data", i), rd_data_o, 64'h0000_0000_1234_5678);
            chk($sformatf("t2_stall%0d_ready", i), 64'(req_ready_o), 64'd0);
        end
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        chk("t2_consumed", 64'(rd_valid_o), 64'd0);

        // SEW16 LMUL1 idx=8 is past VLMAX=8.
        req(5'd0, 7'd8, 2'b01, 2'b00);
        chk("oob1_rd_en", 64'(vrf_rd_en_o), 64'd0);
        chk("oob1_valid", 64'(rd_valid_o), 64'd1);
        chk("oob1_data", rd_data_o, 64'd0);
        chk("oob1_oob", 64'(rd_oob_o), 64'd1);
        chk("oob1_ready", 64'(req_ready_o), 64'd0);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        chk("oob1_consumed", 64'(rd_valid_o), 64'd0);

        // SEW64 LMUL1 idx=2 is past VLMAX=2.
        req(5'd5, 7'd2, 2'b11, 2'b00);
        chk("oob2_rd_en", 64'(vrf_rd_en_o), 64'd0);
        chk("oob2_valid", 64'(rd_valid_o), 64'd1);
        chk("oob2_oob", 64'(rd_oob_o), 64'd1);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;

        run_in("wrap64", 5'd30, 7'd5, 2'b11, 2'b11, 5'd0, 64'hFEDC_BA98_7654_3210);
        run_in("h16neg", 5'd10, 7'd7, 2'b01, 2'b00, 5'd10, 64'hFFFF_FFFF_FFFF_CAFE);
        run_in("b8max", 5'd3, 7'd127, 2'b00, 2'b11, 5'd10, 64'hFFFF_FFFF_FFFF_FFCA);

        // Reset asserted while the read strobe is high.
        req(5'd3, 7'd2, 2'b10, 2'b00);
        chk("rst_mid_rd_en_before", 64'(vrf_rd_en_o), 64'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("rst_mid_rd_en", 64'(vrf_rd_en_o), 64'd0);
        chk("rst_mid_addr", 64'(vrf_rd_addr_o), 64'd0);
        chk("rst_mid_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_mid_data", rd_data_o, 64'd0);
        chk("rst_mid_oob", 64'(rd_oob_o), 64'd0);
        tick();
        rstn_i = 1'b1;
        tick();
        chk("rst_rel_ready", 64'(req_ready_o), 64'd1);
        chk("rst_rel_valid", 64'(rd_valid_o), 64'd0);
        run_in("post_rst", 5'd3, 7'd2, 2'b10, 2'b00, 5'd3, 64'h0000_0000_5566_7788);

        // Flush in CAPTURE drops the result.
        req(5'd3, 7'd5, 2'b00, 2'b00);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_cap_valid", 64'(rd_valid_o), 64'd0);
        chk("flush_cap_ready", 64'(req_ready_o), 64'd1);
        tick();
        chk("flush_cap_no_resp", 64'(rd_valid_o), 64'd0);

        // Flush in IDLE blocks acceptance; flush in READ returns to IDLE.
        vs2_addr_i  = 5'd8;
        elem_idx_i  = 7'd9;
        vsew_i      = 2'b10;
        vlmul_i     = 2'b10;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_idle_rd_en", 64'(vrf_rd_en_o), 64'd0);
        chk("flush_idle_ready", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = 1'b0;
        chk("flush_idle_then_rd_en", 64'(vrf_rd_en_o), 64'd1);
        chk("flush_idle_then_addr", 64'(vrf_rd_addr_o), 64'd10);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_read_rd_en", 64'(vrf_rd_en_o), 64'd0);
        chk("flush_read_addr", 64'(vrf_rd_addr_o), 64'd0);
        chk("flush_read_ready", 64'(req_ready_o), 64'd1);
        tick();
        tick();
        chk("flush_read_no_resp", 64'(rd_valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
